ir_cmd_ctrl: RTL and testbench
==============================

Name: ir_cmd_ctrl

Overview:
- Sequences the NEC IR decoder and turns its held 8-bit `value` into discrete command events for the rest of the design.
- Generates the 0.5625 ms sample strobe and synchronises the raw IR input.
- Tracks key press/hold/release and pulses the decoder reset on release, so a repeated key produces a fresh value.
- Queues commands in a small FIFO with a valid/ready handshake to the consumer (menu/game logic).

Parameters:
- CLK_DIV, 28125: clk cycles per sample tick (50 MHz -> 0.5625 ms).
- FIFO_DEPTH, 4: command FIFO entries; power of two, >=2.
- FRAME_TICKS, 140: max ticks from first activity to a decoded value before the frame is abandoned.
- IDLE_TICKS, 200: consecutive idle (high) ticks that mean key released (~112 ms).
- REPEAT_TICKS, 192: auto-repeat period in ticks (only with IR_REPEAT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ir_in  in  1  raw IR receiver output; idle high, active low
- sample_tick  out  1  one-clk pulse every CLK_DIV clks; clock enable for decoder sampling
- ir_sync  out  1  ir_in after 2-flop synchroniser
- dec_reset  out  1  reset to decoder
- dec_value  in  8  decoder `value` output; 0 = none
- cmd_data  out  8  FIFO head command
- cmd_valid  out  1  FIFO not empty
- cmd_ready  in  1  consumer accepts head this cycle
- key_held  out  1  high while in HELD
- overflow  out  1  sticky: a command was dropped
- clear_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset values:
  - sample_tick=0, ir_sync=1 (both sync flops reset to 1).
  - dec_reset=1 while reset is asserted.
  - cmd_data=0, cmd_valid=0, key_held=0, overflow=0.
  - FIFO empty, divider=0, state=IDLE.
- Divider: counts 0..CLK_DIV-1; sample_tick=1 in the cycle the count is CLK_DIV-1; then wraps to 0.
- All state-machine timers advance only on sample_tick. dec_value is examined every clk.
- IDLE:
  - ir_sync==0 on a tick -> RX; frame timer=0.
- RX:
  - dec_value!=0 -> push dec_value; -> HELD.
  - Otherwise, frame timer reaching FRAME_TICKS -> FLUSH (bad/partial frame, nothing pushed).
- HELD:
  - key_held=1.
  - Idle counter clears on any tick with ir_sync==0 and increments on ticks with ir_sync==1.
  - Idle counter reaching IDLE_TICKS -> FLUSH.
- FLUSH:
  - dec_reset=1 for exactly one clk; timers clear; -> IDLE.
- dec_reset is registered; asserted only during reset or the FLUSH cycle.
- FIFO is show-ahead:
  - cmd_data is always the head entry; cmd_valid = !empty.
  - Pop occurs when cmd_valid & cmd_ready.
  - Push when full and no pop that cycle -> command dropped; overflow<=1.
  - Push and pop in the same cycle while full -> both happen; count unchanged; no overflow.
  - Push and pop in the same cycle while empty -> the push is stored. The pop is void because cmd_valid=0.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- overflow: a set event and clear_ovf in the same cycle -> set wins.
- cmd_data must not change while cmd_valid=1 and cmd_ready=0.
- Reset mid-frame or mid-hold: immediate return to reset values; the FIFO contents are discarded.

Optional Feature:
- Macro: IR_REPEAT_EN.
- With the macro defined:
  - HELD keeps a repeat counter that resets on entry to HELD.
  - Each time the counter reaches REPEAT_TICKS, the last pushed command is pushed again and the counter restarts.
  - Repeats stop on exit from HELD.
  - Repeat pushes obey the same overflow rule.
- Without the macro: exactly one push per press; the REPEAT_TICKS parameter is unused.

Decomposition:
- Shared package ir_pkg contains:
  - typedef enum for the states (IDLE, RX, HELD, FLUSH).
  - typedef ir_cmd_t (logic [7:0]).
  - The constant IR_NONE=8'h00.
  - Default timing constants (CLK_DIV, FRAME_TICKS, IDLE_TICKS, REPEAT_TICKS).
- One sub-module: ir_cmd_fifo (parameterised show-ahead FIFO with full/empty/count).

Test Plan (CLK_DIV=4, FIFO_DEPTH=4, FRAME_TICKS=10, IDLE_TICKS=6, REPEAT_TICKS=8):
- Reset released, ir_in=1 -> sample_tick pulses every 4 clks; dec_reset=0; cmd_valid=0; state stays IDLE.
- ir_in low 1 tick, then dec_value=8'h45 three ticks later, cmd_ready=0 -> cmd_valid=1, cmd_data=8'h45, key_held=1. After 6 idle ticks, dec_reset pulses for 1 clk and key_held=0.
- Same key again: ir_in low, dec_value returns to 8'h45 after flush -> second entry 8'h45 queued; count=2.
- ir_in low, dec_value stays 0 for 10 ticks -> single dec_reset pulse; nothing pushed.
- Five presses with cmd_ready=0 -> 4 entries, overflow=1. Then hold cmd_ready=1 -> entries drain in order; clear_ovf clears overflow.
- IR_REPEAT_EN, press 8'h18 held with ir_in toggling low every 3 ticks for 20 ticks -> pushes at ticks 0, 8, 16 (3 entries of 8'h18). Without the macro -> 1 entry.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types and default timing for the IR command controller.
// Contents: controller state enum, command type, "no command" value,
// default timing constants and a small max helper used for timer sizing.
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RX    = 2'd1,
    HELD  = 2'd2,
    FLUSH = 2'd3
  } ir_state_e;

  typedef logic [7:0] ir_cmd_t;

  localparam ir_cmd_t IR_NONE = 8'h00;

  // 50 MHz clk -> 0.5625 ms sample period
  localparam int DEF_CLK_DIV      = 28125;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_FRAME_TICKS  = 140;
  localparam int DEF_IDLE_TICKS   = 200;
  localparam int DEF_REPEAT_TICKS = 192;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ir_cmd_fifo.sv
// Show-ahead command FIFO.
// Ports:
//   clk, reset        clock, async active-high reset (pointers/count cleared)
//   push, push_data   write request and data
//   pop_req           consumer ready; pop happens only when not empty
//   head_data         head entry (IR_NONE while empty)
//   full              no free entry
//   count             number of stored entries (0..DEPTH)
module ir_cmd_fifo
  import ir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  ir_cmd_t                push_data,
  input  logic                   pop_req,
  output ir_cmd_t                head_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ir_cmd_t       mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    do_pop  = pop_req && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    head_data = empty ? IR_NONE : mem_q[rd_q];
    count     = cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/ir_cmd_ctrl.sv
// NEC IR command controller.
// Generates the decoder sample strobe, synchronises ir_in, sequences the
// decoder (press / hold / release, decoder reset on release) and queues
// decoded commands for a valid/ready consumer.
// Ports:
//   clk, reset            clock, async active-high reset
//   ir_in                 raw IR receiver (idle high)
//   sample_tick, ir_sync  decoder clock enable and synchronised IR input
//   dec_reset, dec_value  decoder reset and held decoded value (0 = none)
//   cmd_data, cmd_valid, cmd_ready   command stream to the consumer
//   key_held              high while a key is held
//   overflow, clear_ovf   sticky dropped-command flag and its clear
// Build option: define IR_REPEAT_EN to auto-repeat the held command every
// REPEAT_TICKS sample ticks.
//
// state | meaning
// IDLE  | waiting for IR activity on a sample tick
// RX    | frame in progress, waiting for a decoded value (frame timer)
// HELD  | command pushed, key held until the line stays idle (idle timer)
// FLUSH | one-clk decoder reset, then back to IDLE
module ir_cmd_ctrl
  import ir_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int FRAME_TICKS  = DEF_FRAME_TICKS,
  parameter int IDLE_TICKS   = DEF_IDLE_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ir_in,
  output logic       sample_tick,
  output logic       ir_sync,
  output logic       dec_reset,
  input  logic [7:0] dec_value,
  output logic [7:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       key_held,
  output logic       overflow,
  input  logic       clear_ovf
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // One width shared by every tick timer.
  localparam int TMR_W = $clog2(max3(FRAME_TICKS, IDLE_TICKS, REPEAT_TICKS) + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             sync1_q, sync2_q;
  ir_state_e        state_q, state_d;
  logic [TMR_W-1:0] frame_q, frame_d;
  logic [TMR_W-1:0] idle_q, idle_d;
  logic             dec_reset_q;
  logic             key_held_q;
  logic             ovf_q, ovf_d;
  logic             push;
  ir_cmd_t          push_data;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
`ifdef IR_REPEAT_EN
  logic [TMR_W-1:0] rep_q, rep_d;
  ir_cmd_t          last_q, last_d;
`endif

  assign ir_sync   = sync2_q;
  assign dec_reset = dec_reset_q;
  assign key_held  = key_held_q;
  assign overflow  = ovf_q;
  assign cmd_valid = (fifo_count != '0);

  always_comb begin
    sample_tick = (div_q == DIV_W'(CLK_DIV - 1));
    div_d       = sample_tick ? '0 : div_q + 1'b1;

    state_d   = state_q;
    frame_d   = frame_q;
    idle_d    = idle_q;
    push      = 1'b0;
    push_data = dec_value;
`ifdef IR_REPEAT_EN
    rep_d  = rep_q;
    last_d = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (sample_tick && !sync2_q) begin
          state_d = RX;
          frame_d = '0;
        end
      end
      RX: begin
        // A decoded value wins over a frame timeout on the same clk.
        if (dec_value != IR_NONE) begin
          push    = 1'b1;
          state_d = HELD;
          idle_d  = '0;
`ifdef IR_REPEAT_EN
          rep_d  = '0;
          last_d = dec_value;
`endif
        end else if (sample_tick) begin
          if (frame_q == TMR_W'(FRAME_TICKS - 1)) begin
            state_d = FLUSH;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      HELD: begin
        if (sample_tick) begin
          if (!sync2_q) begin
            idle_d = '0;
          end else if (idle_q == TMR_W'(IDLE_TICKS - 1)) begin
            state_d = FLUSH;
          end else begin
            idle_d = idle_q + 1'b1;
          end
`ifdef IR_REPEAT_EN
          // No repeat on the tick that releases the key.
          if (state_d == HELD) begin
            if (rep_q == TMR_W'(REPEAT_TICKS - 1)) begin
              push      = 1'b1;
              push_data = last_q;
              rep_d     = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
`endif
        end
      end
      FLUSH: begin
        state_d = IDLE;
        frame_d = '0;
        idle_d  = '0;
`ifdef IR_REPEAT_EN
        rep_d = '0;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Set wins over clear.
    ovf_d = ovf_q;
    if (clear_ovf) begin
      ovf_d = 1'b0;
    end
    if (push && fifo_full && !(cmd_valid && cmd_ready)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      frame_q     <= '0;
      idle_q      <= '0;
      dec_reset_q <= 1'b1;
      key_held_q  <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef IR_REPEAT_EN
      rep_q  <= '0;
      last_q <= IR_NONE;
`endif
    end else begin
      div_q       <= div_d;
      sync1_q     <= ir_in;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      frame_q     <= frame_d;
      idle_q      <= idle_d;
      dec_reset_q <= (state_d == FLUSH);
      key_held_q  <= (state_d == HELD);
      ovf_q       <= ovf_d;
`ifdef IR_REPEAT_EN
      rep_q  <= rep_d;
      last_q <= last_d;
`endif
    end
  end

  ir_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop_req  (cmd_ready),
    .head_data(cmd_data),
    .full     (fifo_full),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// Bench for ir_cmd_ctrl with short timing (CLK_DIV=4, FIFO_DEPTH=4,
// FRAME_TICKS=10, IDLE_TICKS=6, REPEAT_TICKS=8). Inputs change 1 ns after
// the rising edge; the pop monitor samples on the falling edge.
module tb_ir_cmd_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10;
  localparam int IDLE_T  = 6;
  localparam int REP     = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ir_in = 1'b1;
  logic [7:0] dec_value = 8'h00;
  logic       cmd_ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       sample_tick;
  logic       ir_sync;
  logic       dec_reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       key_held;
  logic       overflow;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  always #5 clk = ~clk;

  ir_cmd_ctrl #(
    .CLK_DIV     (CLK_DIV),
    .FIFO_DEPTH  (DEPTH),
    .FRAME_TICKS (FRAME),
    .IDLE_TICKS  (IDLE_T),
    .REPEAT_TICKS(REP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ir_in      (ir_in),
    .sample_tick(sample_tick),
    .ir_sync    (ir_sync),
    .dec_reset  (dec_reset),
    .dec_value  (dec_value),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .key_held   (key_held),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every accepted pop must match the oldest expected command.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) check_eq("pop_unexpected", exp_q.size(), 1);
      else check_eq("pop_data", cmd_data, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle whose closing edge is a sample tick.
  task automatic next_tick();
    bit found = 0;
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      step();
      if (sample_tick) begin
        found = 1;
        break;
      end
    end
    if (!found) check_eq("tick_timeout", sample_tick, 1);
  endtask

  // Counts ticks until dec_reset, then models the decoder clearing its value.
  task automatic wait_flush(output int ticks);
    bit found = 0;
    ticks = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (dec_reset) begin
        found = 1;
        break;
      end
      if (sample_tick) ticks++;
    end
    if (!found) check_eq("flush_timeout", dec_reset, 1);
    dec_value = 8'h00;
    step();
    check_eq("dec_reset_width", dec_reset, 0);
  endtask

  // One low tick on ir_in, decoded value three ticks later; returns in HELD.
  task automatic press_key(input logic [7:0] val, input bit pulse_ready);
    bit pop_now;
    next_tick();
    ir_in = 1'b0;
    next_tick();
    ir_in = 1'b1;
    repeat (3) next_tick();
    dec_value = val;
    if (pulse_ready) cmd_ready = 1'b1;
    pop_now = cmd_ready && (exp_q.size() > 0);
    if (exp_q.size() < DEPTH || pop_now) exp_q.push_back(val);
    else exp_ovf = 1'b1;
    step();
    if (pulse_ready) cmd_ready = 1'b0;
    check_eq("key_held_on", key_held, 1);
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    for (int i = 0; i < 20 && cmd_valid; i++) step();
    step();
    cmd_ready = 1'b0;
    check_eq("drain_valid", cmd_valid, 0);
    check_eq("drain_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int t;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tick", sample_tick, 0);
    check_eq("rst_ir_sync", ir_sync, 1);
    check_eq("rst_dec_reset", dec_reset, 1);
    check_eq("rst_cmd_data", cmd_data, 0);
    check_eq("rst_cmd_valid", cmd_valid, 0);
    check_eq("rst_key_held", key_held, 0);
    check_eq("rst_overflow", overflow, 0);
    reset = 1'b0;

    // Tick period and idle state
    next_tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (sample_tick) break;
    end
    check_eq("tick_period", n, CLK_DIV);
    check_eq("idle_dec_reset", dec_reset, 0);
    check_eq("idle_cmd_valid", cmd_valid, 0);
    check_eq("idle_key_held", key_held, 0);

    // First press, held until release
    press_key(8'h45, 0);
    check_eq("press_valid", cmd_valid, 1);
    check_eq("press_data", cmd_data, 8'h45);
    wait_flush(t);
    check_eq("idle_ticks", t, IDLE_T);
    check_eq("release_key_held", key_held, 0);

    // Same key again gives a second entry
    press_key(8'h45, 0);
    wait_flush(t);
    check_eq("second_idle_ticks", t, IDLE_T);

    // Frame without a decoded value
    next_tick();
    ir_in = 1'b0;
    next_tick();
    ir_in = 1'b1;
    wait_flush(t);
    check_eq("frame_ticks", t, FRAME);
    check_eq("frame_key_held", key_held, 0);
    check_eq("frame_head", cmd_data, 8'h45);
    drain();

    // Five presses into a four-entry FIFO
    press_key(8'h11, 0); wait_flush(t);
    press_key(8'h22, 0); wait_flush(t);
    press_key(8'h33, 0); wait_flush(t);
    press_key(8'h44, 0); wait_flush(t);
    check_eq("full_no_ovf", overflow, 0);
    press_key(8'h55, 0); wait_flush(t);
    check_eq("overflow_set", overflow, exp_ovf);
    check_eq("head_stable", cmd_data, 8'h11);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check_eq("overflow_clear", overflow, 0);

    // Push and pop together while full: no drop
    press_key(8'h66, 1);
    wait_flush(t);
    check_eq("full_pushpop_ovf", overflow, 0);
    drain();

    // Push while empty with the consumer ready
    cmd_ready = 1'b1;
    press_key(8'h77, 0);
    wait_flush(t);
    step();
    cmd_ready = 1'b0;
    check_eq("empty_pushpop_sb", exp_q.size(), 0);
    check_eq("empty_pushpop_valid", cmd_valid, 0);

    // Long hold with short gaps on the line
    press_key(8'h18, 0);
`ifdef IR_REPEAT_EN
    exp_q.push_back(8'h18);
    exp_q.push_back(8'h18);
`endif
    for (int k = 1; k <= 16; k++) begin
      next_tick();
      ir_in = (k % 3 == 0) ? 1'b0 : 1'b1;
    end
    ir_in = 1'b1;
    wait_flush(t);
    check_eq("hold_release_ticks", t, IDLE_T);
    drain();

    // Reset in the middle of a hold discards everything
    press_key(8'h99, 0);
    next_tick();
    reset = 1'b1;
    #1;
    check_eq("midrst_valid", cmd_valid, 0);
    check_eq("midrst_key_held", key_held, 0);
    check_eq("midrst_dec_reset", dec_reset, 1);
    check_eq("midrst_data", cmd_data, 0);
    exp_q.delete();
    dec_value = 8'h00;
    step();
    reset = 1'b0;
    step();
    check_eq("post_rst_dec_reset", dec_reset, 0);
    press_key(8'h5a, 0);
    check_eq("post_rst_data", cmd_data, 8'h5a);
    wait_flush(t);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
